multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// Multi-cycle control unit for the RV32I core. Sequences fetch, decode, execute,
// memory and writeback of one instruction at a time over the shared ALU, register
// file and memory port. Drives all datapath enables and muxes, and handshakes with
// the memory interface. Sits beside the datapath in cpu; instr comes from the
// instruction register it loads.
// PARAMETERS
// CNT_W     32   width of the retired-instruction counter
// MEM_TMO   255  cycles a memory request may wait on mem_ready before trap (0 = never)
// PORTS
// clk          in   1      rising-edge clock
// reset        in   1      synchronous, active-high
// instr        in   32     instruction-register contents (valid from DECODE on)
// mem_ready    in   1      memory completed current request this cycle
// alu_zero     in   1      ALU result == 0 (used in EXECUTE for branches)
// ir_write     out  1      load instruction register from memory read data
// pc_write     out  1      update PC this cycle
// pc_sel       out  1      0 = PC+4, 1 = branch/jump target
// reg_write    out  1      register-file write enable (never for rd==x0)
// wb_sel       out  2      00 ALU, 01 memory data, 10 PC+4
// alu_src_a    out  1      0 PC, 1 rs1
// alu_src_b    out  2      00 rs2, 01 const 4, 10 immediate
// alu_ctrl     out  4      0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 0111 slt
// mem_req      out  1      memory request valid; held until mem_ready
// mem_we       out  1      1 = store, qualified by mem_req
// state        out  3      current state (debug)
// trap         out  1      sticky illegal-opcode / memory-timeout flag
// instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
// - States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7. Registered state;
//   all outputs decoded from state and instr, except ir_write/pc_write, which are
//   also qualified by mem_ready.
// - Reset (synchronous): next state FETCH, trap=0, instr_count=0. While reset is
//   high, every output is 0. An outstanding request is abandoned; mem_req drops.
// - FETCH: mem_req=1, mem_we=0. On mem_ready: ir_write=1, go to DECODE.
//   Otherwise stay, counting wait cycles.
// - DECODE: 1 cycle. Opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (LW),
//   0100011 (SW), 1100011 (BEQ/BNE) and 1101111 (JAL) go to EXECUTE. Any other
//   opcode goes to TRAP.
// - EXECUTE, 1 cycle:
//   - R: alu_src_a=1, alu_src_b=00, alu_ctrl from funct3/funct7.
//     funct3=000 with funct7[5]=1 -> sub.
//   - I-ALU: alu_src_b=10, same funct3 map, no sub.
//   - LW/SW: add with imm, then go to MEM.
//   - Branch: sub. pc_write=1 every time; pc_sel = alu_zero XNOR (funct3==000)
//     (taken). Then retire and go to FETCH.
//   - JAL: go to WB.
// - MEM: mem_req=1, mem_we=1 for SW. Hold until mem_ready. Then LW -> WB;
//   SW -> pc_write=1, pc_sel=0, retire, go to FETCH.
// - WB: 1 cycle. reg_write=(rd!=0). wb_sel is 00 for R/I, 01 for LW, 10 for JAL.
//   pc_write=1; pc_sel=1 only for JAL. Retire, go to FETCH.
// - Retire means instr_count+1 on the same edge as the state change to FETCH.
// - Latency with zero-wait memory: branch 3 cycles; R/I/SW/JAL 4; LW 5.
//   Each wait cycle adds 1.
// - Timeout: if MEM_TMO!=0 and mem_ready stays low for MEM_TMO consecutive cycles
//   in FETCH or MEM, go to TRAP. The wait counter clears on every state entry.
// - TRAP: trap=1, all enables 0, mem_req=0. Held until reset.
// - mem_ready outside FETCH/MEM is ignored.
// TESTING
// - Reset: hold reset 2 cycles mid-LW (state=MEM, mem_req=1) -> next cycle
//   state=0, mem_req=0, instr_count=0, trap=0.
// - add x3,x1,x2 (0x002081B3), mem_ready tied 1 -> states 0,1,2,4.
//   In EXECUTE alu_ctrl=0010. In WB reg_write=1, wb_sel=00, pc_write=1.
//   instr_count=1.
// - lw x5,8(x0), fetch 2 wait cycles, MEM 1 wait cycle -> 8 cycles total.
//   wb_sel=01 in WB.
// - beq x1,x1 with alu_zero=1 -> pc_write=1, pc_sel=1 in EXECUTE. Same with bne
//   -> pc_sel=0. 3 cycles each.
// - add x0,x1,x2 -> reg_write stays 0 all cycles. instr_count still increments.
// - Opcode 0x7F -> TRAP (state=7, trap=1) after DECODE, stays until reset.
//   mem_ready held 0 for 255 cycles in FETCH -> trap=1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/mem/writeback.
// Outputs decode the registered state (plus instr, and mem_ready for ir_write/pc_write).
// Stalls in FETCH/MEM until i_mem_ready; a bounded wait traps to TRAP (MEM_TMO=0 disables).
module multicycle_control_fsm #(
    parameter int CNT_W   = 32,
    parameter int MEM_TMO = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_instr,
    input  logic             i_mem_ready,
    input  logic             i_alu_zero,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_pc_sel,
    output logic             o_reg_write,
    output logic [1:0]       o_wb_sel,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [3:0]       o_alu_ctrl,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [2:0]       o_state,
    output logic             o_trap,
    output logic [CNT_W-1:0] o_instr_count
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd7
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam int TMO_W = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;

    state_t             r_state;
    logic [TMO_W-1:0]   r_wait;
    logic [CNT_W-1:0]   r_count;
    logic               r_trap;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_rd_nz;
    logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_legal;
    logic       w_br_taken;
    logic       w_tmo;
    logic [3:0] w_alu_funct;
    logic       w_unused_instr;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_rd_nz  = |i_instr[11:7];

    assign w_is_r   = (w_opcode == OP_R);
    assign w_is_i   = (w_opcode == OP_I);
    assign w_is_lw  = (w_opcode == OP_LW);
    assign w_is_sw  = (w_opcode == OP_SW);
    assign w_is_br  = (w_opcode == OP_BR);
    assign w_is_jal = (w_opcode == OP_JAL);
    assign w_legal  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br | w_is_jal;

    // BEQ (funct3=000) is taken on zero, BNE on non-zero.
    assign w_br_taken = i_alu_zero ~^ (w_funct3 == 3'b000);

    // Fires on the MEM_TMO-th consecutive cycle without mem_ready.
    assign w_tmo = (MEM_TMO != 0) && !i_mem_ready && (r_wait == TMO_W'(MEM_TMO - 1));

    assign w_unused_instr = ^{i_instr[31], i_instr[29:15]};

    always_comb begin
        w_alu_funct = ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_funct = (w_is_r && i_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b111:  w_alu_funct = ALU_AND;
            3'b110:  w_alu_funct = ALU_OR;
            3'b100:  w_alu_funct = ALU_XOR;
            3'b010:  w_alu_funct = ALU_SLT;
            default: w_alu_funct = ALU_ADD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_count <= '0;
            r_trap  <= 1'b0;
        end else begin
            r_wait <= '0;
            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_tmo) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end else if (MEM_TMO != 0) begin
                        r_wait <= r_wait + TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXECUTE;
                    end else begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    if (w_is_lw || w_is_sw) begin
                        r_state <= S_MEM;
                    end else if (w_is_br) begin
                        r_state <= S_FETCH;
                        r_count <= r_count + CNT_W'(1);
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        if (w_is_sw) begin
                            r_state <= S_FETCH;
                            r_count <= r_count + CNT_W'(1);
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_tmo) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end else if (MEM_TMO != 0) begin
                        r_wait <= r_wait + TMO_W'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_count <= r_count + CNT_W'(1);
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_TRAP;
                    r_trap  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        o_ir_write  = 1'b0;
        o_pc_write  = 1'b0;
        o_pc_sel    = 1'b0;
        o_reg_write = 1'b0;
        o_wb_sel    = 2'b00;
        o_alu_src_a = 1'b0;
        o_alu_src_b = 2'b00;
        o_alu_ctrl  = ALU_ADD;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req  = 1'b1;
                    o_ir_write = i_mem_ready;
                end
                S_EXECUTE: begin
                    o_alu_src_a = 1'b1;
                    if (w_is_r) begin
                        o_alu_src_b = 2'b00;
                        o_alu_ctrl  = w_alu_funct;
                    end else if (w_is_i) begin
                        o_alu_src_b = 2'b10;
                        o_alu_ctrl  = w_alu_funct;
                    end else if (w_is_lw || w_is_sw) begin
                        o_alu_src_b = 2'b10;
                        o_alu_ctrl  = ALU_ADD;
                    end else if (w_is_br) begin
                        o_alu_src_b = 2'b00;
                        o_alu_ctrl  = ALU_SUB;
                        o_pc_write  = 1'b1;
                        o_pc_sel    = w_br_taken;
                    end else if (w_is_jal) begin
                        o_alu_src_a = 1'b0;
                        o_alu_src_b = 2'b10;
                        o_alu_ctrl  = ALU_ADD;
                    end
                end
                S_MEM: begin
                    o_mem_req  = 1'b1;
                    o_mem_we   = w_is_sw;
                    o_pc_write = w_is_sw & i_mem_ready;
                end
                S_WB: begin
                    o_reg_write = w_rd_nz;
                    o_wb_sel    = w_is_lw ? 2'b01 : (w_is_jal ? 2'b10 : 2'b00);
                    o_pc_write  = 1'b1;
                    o_pc_sel    = w_is_jal;
                end
                default: ;
            endcase
        end
    end

    assign o_state       = i_reset ? 3'd0 : r_state;
    assign o_trap        = !i_reset && r_trap;
    assign o_instr_count = i_reset ? '0 : r_count;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: expected per-cycle control vectors are
// queued as stimulus is driven and popped against the DUT at the falling edge.
module tb_multicycle_control_fsm;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        ir_write, pc_write, pc_sel, reg_write, alu_src_a, mem_req, mem_we, trap;
    logic [1:0]  wb_sel, alu_src_b;
    logic [3:0]  alu_ctrl;
    logic [2:0]  state;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.CNT_W(32), .MEM_TMO(255)) dut (
        .i_clk(clk), .i_reset(reset), .i_instr(instr), .i_mem_ready(mem_ready),
        .i_alu_zero(alu_zero), .o_ir_write(ir_write), .o_pc_write(pc_write),
        .o_pc_sel(pc_sel), .o_reg_write(reg_write), .o_wb_sel(wb_sel),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_ctrl(alu_ctrl),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_state(state), .o_trap(trap),
        .o_instr_count(instr_count)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, irw, pcw, pcs, rw;
        logic [1:0] wb;
        logic       trp;
        logic       chk;
        logic [3:0] alu;
        logic       sa;
        logic [1:0] sb;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic req, input logic we,
                                input logic irw, input logic pcw, input logic pcs,
                                input logic rw, input logic [1:0] wb, input logic trp);
        exp_t e;
        e     = '0;
        e.st  = st;  e.req = req; e.we  = we;  e.irw = irw;
        e.pcw = pcw; e.pcs = pcs; e.rw  = rw;  e.wb  = wb;  e.trp = trp;
        return e;
    endfunction

    function automatic exp_t mk_ex(input logic [3:0] alu, input logic [1:0] sb);
        exp_t e;
        e     = mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        e.chk = 1'b1; e.alu = alu; e.sa = 1'b1; e.sb = sb;
        return e;
    endfunction

    // pc_sel is only meaningful with pc_write, wb_sel only in WB.
    task automatic compare_front(input string tag);
        exp_t        x;
        logic [11:0] gv, ev;
        x  = sb_q.pop_front();
        gv = {state, mem_req, mem_we, ir_write, pc_write, pc_write & pc_sel, reg_write,
              (state == 3'd4) ? wb_sel : 2'b00, trap};
        ev = {x.st, x.req, x.we, x.irw, x.pcw, x.pcw & x.pcs, x.rw,
              (x.st == 3'd4) ? x.wb : 2'b00, x.trp};
        check(tag, 32'(gv), 32'(ev));
        if (x.chk)
            check({tag, "/alu"}, 32'({alu_ctrl, alu_src_a, alu_src_b}), 32'({x.alu, x.sa, x.sb}));
    endtask

    task automatic step(input logic rdy, input logic zero, input exp_t e, input string tag);
        mem_ready = rdy;
        alu_zero  = zero;
        sb_q.push_back(e);
        @(negedge clk);
        compare_front(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input string tag);
        exp_cnt = exp_cnt + 1;
        check({tag, "/cnt"}, instr_count, exp_cnt);
        check({tag, "/st"}, 32'(state), 32'd0);
    endtask

    task automatic run_alu(input logic [31:0] ins, input logic [3:0] alu, input logic [1:0] sb,
                           input string tag);
        logic rw;
        rw    = (ins[11:7] != 5'd0);
        instr = ins;
        step(1, 0, mk(3'd0, 1, 0, 1, 0, 0, 0, 2'b00, 0), {tag, "/F"});
        step(1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0), {tag, "/D"});
        step(1, 0, mk_ex(alu, sb), {tag, "/E"});
        step(1, 0, mk(3'd4, 0, 0, 0, 1, 0, rw, 2'b00, 0), {tag, "/WB"});
        retire(tag);
    endtask

    task automatic run_br(input logic [31:0] ins, input logic zero, input logic taken,
                          input string tag);
        exp_t e;
        instr = ins;
        step(1, 0, mk(3'd0, 1, 0, 1, 0, 0, 0, 2'b00, 0), {tag, "/F"});
        step(1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0), {tag, "/D"});
        e     = mk_ex(ALU_SUB, 2'b00);
        e.pcw = 1'b1;
        e.pcs = taken;
        step(1, zero, e, {tag, "/E"});
        retire(tag);
    endtask

    initial begin
        reset     = 1'b1;
        instr     = 32'h0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        exp_cnt   = 32'd0;
        @(posedge clk);
        #1;
        step(0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "rst0");
        step(1, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "rst1");
        check("rst/cnt", instr_count, 32'd0);
        reset = 1'b0;

        run_alu(32'h002081B3, ALU_ADD, 2'b00, "add");
        run_alu(32'h402081B3, ALU_SUB, 2'b00, "sub");
        run_alu(32'h0020E1B3, ALU_OR,  2'b00, "or");
        run_alu(32'h0020F1B3, ALU_AND, 2'b00, "and");
        run_alu(32'h0020A1B3, ALU_SLT, 2'b00, "slt");
        run_alu(32'h0020C1B3, ALU_XOR, 2'b00, "xor");
        run_alu(32'h40000093, ALU_ADD, 2'b10, "addi_b30");
        run_alu(32'h0040C113, ALU_XOR, 2'b10, "xori");
        run_alu(32'h00208033, ALU_ADD, 2'b00, "add_x0");

        // lw x5,8(x0): two fetch waits, one memory wait -> 8 cycles
        instr = 32'h00802283;
        step(0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'b00, 0), "lw/F0");
        step(0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'b00, 0), "lw/F1");
        step(1, 0, mk(3'd0, 1, 0, 1, 0, 0, 0, 2'b00, 0), "lw/F2");
        step(1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0), "lw/D");
        step(1, 0, mk_ex(ALU_ADD, 2'b10), "lw/E");
        step(0, 0, mk(3'd3, 1, 0, 0, 0, 0, 0, 2'b00, 0), "lw/M0");
        step(1, 0, mk(3'd3, 1, 0, 0, 0, 0, 0, 2'b00, 0), "lw/M1");
        step(1, 0, mk(3'd4, 0, 0, 0, 1, 0, 1, 2'b01, 0), "lw/WB");
        retire("lw");

        // sw x5,12(x0)
        instr = 32'h00502623;
        step(1, 0, mk(3'd0, 1, 0, 1, 0, 0, 0, 2'b00, 0), "sw/F");
        step(1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0), "sw/D");
        step(1, 0, mk_ex(ALU_ADD, 2'b10), "sw/E");
        step(1, 0, mk(3'd3, 1, 1, 0, 1, 0, 0, 2'b00, 0), "sw/M");
        retire("sw");

        run_br(32'h00108063, 1'b1, 1'b1, "beq_z1");
        run_br(32'h00109063, 1'b1, 1'b0, "bne_z1");
        run_br(32'h00108063, 1'b0, 1'b0, "beq_z0");
        run_br(32'h00109063, 1'b0, 1'b1, "bne_z0");

        // jal x1,0
        instr = 32'h000000EF;
        step(1, 0, mk(3'd0, 1, 0, 1, 0, 0, 0, 2'b00, 0), "jal/F");
        step(1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0), "jal/D");
        step(1, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0), "jal/E");
        step(1, 0, mk(3'd4, 0, 0, 0, 1, 1, 1, 2'b10, 0), "jal/WB");
        retire("jal");

        // reset while an LW is waiting in MEM
        instr = 32'h00802283;
        step(1, 0, mk(3'd0, 1, 0, 1, 0, 0, 0, 2'b00, 0), "rstm/F");
        step(1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0), "rstm/D");
        step(1, 0, mk_ex(ALU_ADD, 2'b10), "rstm/E");
        step(0, 0, mk(3'd3, 1, 0, 0, 0, 0, 0, 2'b00, 0), "rstm/M");
        reset = 1'b1;
        step(0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "rstm/R0");
        step(1, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "rstm/R1");
        reset   = 1'b0;
        exp_cnt = 32'd0;
        check("rstm/cnt", instr_count, exp_cnt);

        // illegal opcode traps after DECODE and stays there
        instr = 32'h0000007F;
        step(1, 0, mk(3'd0, 1, 0, 1, 0, 0, 0, 2'b00, 0), "ill/F");
        step(1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0), "ill/D");
        for (int i = 0; i < 4; i++)
            step(logic'(i[0]), 0, mk(3'd7, 0, 0, 0, 0, 0, 0, 2'b00, 1), "ill/T");
        check("ill/cnt", instr_count, exp_cnt);
        reset = 1'b1;
        step(1, 0, mk(3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0), "ill/R");
        reset = 1'b0;

        // fetch timeout: 255 cycles without mem_ready
        instr = 32'h002081B3;
        for (int i = 0; i < 255; i++)
            step(0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'b00, 0), $sformatf("tmo/F%0d", i));
        step(0, 0, mk(3'd7, 0, 0, 0, 0, 0, 0, 2'b00, 1), "tmo/T0");
        step(1, 0, mk(3'd7, 0, 0, 0, 0, 0, 0, 2'b00, 1), "tmo/T1");

        check("sb/empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
